// File: rtl/img_rsz_pkg.sv
// img_rsz_pkg: shared pixel/row types and forwarding FSM states for the resize row streamer.
// Rev 1.0
`default_nettype none

package img_rsz_pkg;

  // Default geometry; the modules re-derive widths from their own parameters.
  localparam int RSZ_PKG_COLOR_W   = 8;
  localparam int RSZ_PKG_COLOR_NUM = 3;
  localparam int RSZ_PKG_WIDTH     = 8;

  typedef logic [RSZ_PKG_COLOR_W-1:0] RszPxlData_t;
  typedef RszPxlData_t [RSZ_PKG_COLOR_NUM-1:0][RSZ_PKG_WIDTH-1:0] RszPxlRow_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rsz_fwd_state_e;

endpackage

`default_nettype wire

// File: rtl/img_rsz_row_sel.sv
// img_rsz_row_sel: row-completion detect and next-row selection (IMG_RSZ_FWD_OOO_EN selects
// lowest-ready out-of-order mode instead of strict row order). Rev 1.0
`default_nettype none

module img_rsz_row_sel
  import img_rsz_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  localparam int POS_W = $clog2(HEIGHT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [HEIGHT-1:0][WIDTH-1:0]  blk_is_exec,
  input  logic                          capture,
  output logic                          tgt_vld,
  output logic [POS_W-1:0]              tgt_row,
  output logic                          tgt_last
);

  localparam logic [POS_W-1:0] LAST_ROW = POS_W'(HEIGHT - 1);

  logic [HEIGHT-1:0] row_done;

  for (genvar h = 0; h < HEIGHT; h++) begin : g_row_done
    assign row_done[h] = &blk_is_exec[h];
  end

`ifdef IMG_RSZ_FWD_OOO_EN
  logic [HEIGHT-1:0] done_mask;
  logic [POS_W-1:0]  cap_cnt;

  // Downward scan so the lowest eligible index wins.
  always_comb begin
    tgt_vld = 1'b0;
    tgt_row = '0;
    for (int h = HEIGHT - 1; h >= 0; h--) begin
      if (row_done[h] && !done_mask[h]) begin
        tgt_vld = 1'b1;
        tgt_row = POS_W'(h);
      end
    end
  end

  assign tgt_last = (cap_cnt == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      done_mask <= '0;
      cap_cnt   <= '0;
    end else if (capture) begin
      if (tgt_last) begin
        done_mask <= '0;
        cap_cnt   <= '0;
      end else begin
        done_mask <= done_mask | (HEIGHT'(1) << tgt_row);
        cap_cnt   <= cap_cnt + POS_W'(1);
      end
    end
  end
`else
  logic [POS_W-1:0] row_ptr;

  assign tgt_row  = row_ptr;
  assign tgt_vld  = row_done[row_ptr];
  assign tgt_last = (row_ptr == LAST_ROW);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_ptr <= '0;
    end else if (capture) begin
      row_ptr <= tgt_last ? '0 : row_ptr + POS_W'(1);
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/img_rsz_row_stream.sv
// img_rsz_row_stream: forwards completed resized rows one per handshake and flushes them from the
// buffer; IMG_RSZ_FWD_OOO_EN enables out-of-order row forwarding. Rev 1.0
`default_nettype none

module img_rsz_row_stream
  import img_rsz_pkg::*;
#(
  parameter int RSZ_IMG_WIDTH_SIZE  = 8,
  parameter int RSZ_IMG_HEIGHT_SIZE = 8,
  parameter int PXL_PRIM_COLOR_W    = 8,
  parameter int PXL_PRIM_COLOR_NUM  = 3,
  parameter int FRM_CNT_W           = 16,
  localparam int POS_W = $clog2(RSZ_IMG_HEIGHT_SIZE)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0][PXL_PRIM_COLOR_W-1:0] FcRszPxlBuf,
  input  logic [RSZ_IMG_HEIGHT_SIZE-1:0][RSZ_IMG_WIDTH_SIZE-1:0] BlkIsExec,
  output logic [RSZ_IMG_HEIGHT_SIZE-1:0] FlushBlkYMsk,
  output logic                           FlushVld,
  output logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_IMG_WIDTH_SIZE-1:0][PXL_PRIM_COLOR_W-1:0] FwdRszRowDat,
  output logic [POS_W-1:0]               FwdRszPosY,
  output logic                           FwdRszLast,
  output logic                           FwdRszVld,
  input  logic                           FwdRszRdy,
  output logic [FRM_CNT_W-1:0]           FwdFrmCnt
);

  rsz_fwd_state_e state;

  logic             tgt_vld;
  logic             tgt_last;
  logic [POS_W-1:0] tgt_row;
  logic             handshake;
  logic             capture;
  logic [PXL_PRIM_COLOR_NUM-1:0][RSZ_IMG_WIDTH_SIZE-1:0][PXL_PRIM_COLOR_W-1:0] row_dat;

  img_rsz_row_sel #(
    .WIDTH  (RSZ_IMG_WIDTH_SIZE),
    .HEIGHT (RSZ_IMG_HEIGHT_SIZE)
  ) u_row_sel (
    .clk         (Clk),
    .rst         (Reset),
    .blk_is_exec (BlkIsExec),
    .capture     (capture),
    .tgt_vld     (tgt_vld),
    .tgt_row     (tgt_row),
    .tgt_last    (tgt_last)
  );

  assign handshake = FwdRszVld & FwdRszRdy;
  // Reset gating keeps a handshake during reset from flushing a row that is then discarded.
  assign capture   = ~Reset & tgt_vld & ((state == ST_IDLE) | handshake);

  assign FlushVld     = capture;
  assign FlushBlkYMsk = capture ? (RSZ_IMG_HEIGHT_SIZE'(1) << tgt_row) : '0;

  always_comb begin
    row_dat = '0;
    for (int c = 0; c < PXL_PRIM_COLOR_NUM; c++) begin
      for (int w = 0; w < RSZ_IMG_WIDTH_SIZE; w++) begin
        row_dat[c][w] = FcRszPxlBuf[c][tgt_row][w];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= ST_IDLE;
      FwdRszVld    <= 1'b0;
      FwdRszLast   <= 1'b0;
      FwdRszPosY   <= '0;
      FwdRszRowDat <= '0;
      FwdFrmCnt    <= '0;
    end else begin
      if (capture) begin
        FwdRszRowDat <= row_dat;
        FwdRszPosY   <= tgt_row;
        FwdRszLast   <= tgt_last;
        FwdRszVld    <= 1'b1;
        state        <= ST_SEND;
      end else if (handshake) begin
        FwdRszVld    <= 1'b0;
        state        <= ST_IDLE;
      end
      if (handshake && FwdRszLast) begin
        FwdFrmCnt <= FwdFrmCnt + FRM_CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_img_rsz_row_stream.sv
// Self-checking bench for img_rsz_row_stream (WIDTH=4, HEIGHT=3, COLOR_NUM=3, FRM_CNT_W=2).
`default_nettype none

module tb_img_rsz_row_stream;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int CN = 3;
  localparam int CW = 8;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [CN-1:0][H-1:0][W-1:0][CW-1:0] pix;
  logic [H-1:0][W-1:0] blk;
  logic [H-1:0] fmask;
  logic fvld;
  logic [CN-1:0][W-1:0][CW-1:0] dat;
  logic [1:0] posy;
  logic last, vld, rdy;
  logic [FW-1:0] frm;

  always #5 clk = ~clk;

  img_rsz_row_stream #(
    .RSZ_IMG_WIDTH_SIZE  (W),
    .RSZ_IMG_HEIGHT_SIZE (H),
    .PXL_PRIM_COLOR_W    (CW),
    .PXL_PRIM_COLOR_NUM  (CN),
    .FRM_CNT_W           (FW)
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .FcRszPxlBuf  (pix),
    .BlkIsExec    (blk),
    .FlushBlkYMsk (fmask),
    .FlushVld     (fvld),
    .FwdRszRowDat (dat),
    .FwdRszPosY   (posy),
    .FwdRszLast   (last),
    .FwdRszVld    (vld),
    .FwdRszRdy    (rdy),
    .FwdFrmCnt    (frm)
  );

  typedef struct packed {
    logic [CN-1:0][W-1:0][CW-1:0] dat;
    logic [1:0]                   posy;
    logic                         last;
  } exp_t;

  typedef struct {
    logic [H-1:0] comp;
    logic         rdy;
    logic         fv;
    logic [H-1:0] mask;
    logic         vld;
  } vec_t;

  exp_t q[$];
  vec_t vecs[$];
  int total = 0;
  int bad = 0;
  int cap_cnt = 0;
  logic [FW-1:0] exp_frm = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic [H-1:0] comp, input logic r, input logic fv,
                      input logic [H-1:0] mask, input logic v);
    vec_t e;
    e.comp = comp; e.rdy = r; e.fv = fv; e.mask = mask; e.vld = v;
    vecs.push_back(e);
  endtask

  // Checks one cycle at the falling edge, then emulates the buffer clearing flushed rows.
  task automatic tick(input logic efv, input logic [H-1:0] emask, input logic evld);
    logic [H-1:0] flushed;
    @(negedge clk);
    chk("flush_vld", 128'(fvld), 128'(efv));
    chk("flush_mask", 128'(fmask), 128'(emask));
    chk("fwd_vld", 128'(vld), 128'(evld));
    chk("frm_cnt", 128'(frm), 128'(exp_frm));
    if (vld === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_empty", 128'(1), 128'(0));
      end else begin
        chk("row_dat", 128'(dat), 128'(q[0].dat));
        chk("pos_y", 128'(posy), 128'(q[0].posy));
        chk("last", 128'(last), 128'(q[0].last));
        if (rdy) begin
          if (q[0].last) exp_frm = exp_frm + FW'(1);
          void'(q.pop_front());
        end
      end
    end
    flushed = (fvld === 1'b1) ? fmask : '0;
    @(posedge clk);
    #1;
    for (int h = 0; h < H; h++) if (flushed[h]) blk[h] = '0;
  endtask

  task automatic step(input logic [H-1:0] comp, input logic r, input logic efv,
                      input logic [H-1:0] emask, input logic evld);
    exp_t e;
    int row;
    for (int h = 0; h < H; h++) begin
      if (comp[h]) begin
        for (int c = 0; c < CN; c++)
          for (int w = 0; w < W; w++) pix[c][h][w] = CW'($urandom);
        blk[h] = '1;
      end
    end
    rdy = r;
    if (efv) begin
      row = 0;
      for (int h = 0; h < H; h++) if (emask[h]) row = h;
      for (int c = 0; c < CN; c++)
        for (int w = 0; w < W; w++) e.dat[c][w] = pix[c][row][w];
      e.posy = 2'(row);
      e.last = (cap_cnt == H - 1);
      cap_cnt = (cap_cnt == H - 1) ? 0 : cap_cnt + 1;
      q.push_back(e);
    end
    tick(efv, emask, evld);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    pix = '0;
    blk = '0;
    rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", 128'(vld), 128'(0));
    chk("rst_posy", 128'(posy), 128'(0));
    chk("rst_last", 128'(last), 128'(0));
    chk("rst_dat", 128'(dat), 128'(0));
    chk("rst_frm", 128'(frm), 128'(0));
    chk("rst_fvld", 128'(fvld), 128'(0));
    chk("rst_fmask", 128'(fmask), 128'(0));
    rst = 1'b0;

    // Frame 1: rows stream back to back.
    addv(3'b001, 1, 1, 3'b001, 0);
    addv(3'b010, 1, 1, 3'b010, 1);
    addv(3'b100, 1, 1, 3'b100, 1);
    addv(3'b000, 1, 0, 3'b000, 1);
    addv(3'b000, 1, 0, 3'b000, 0);
    // Frame 2: five stalled cycles, row 1 completes during the stall.
    addv(3'b001, 0, 1, 3'b001, 0);
    addv(3'b010, 0, 0, 3'b000, 1);
    addv(3'b000, 0, 0, 3'b000, 1);
    addv(3'b000, 0, 0, 3'b000, 1);
    addv(3'b000, 0, 0, 3'b000, 1);
    addv(3'b000, 0, 0, 3'b000, 1);
    addv(3'b000, 1, 1, 3'b010, 1);
    addv(3'b000, 1, 0, 3'b000, 1);
    addv(3'b000, 1, 0, 3'b000, 0);
    addv(3'b100, 1, 1, 3'b100, 0);
    addv(3'b000, 1, 0, 3'b000, 1);
    // Frame 3: row 2 completes first.
`ifdef IMG_RSZ_FWD_OOO_EN
    addv(3'b100, 1, 1, 3'b100, 0);
    addv(3'b000, 1, 0, 3'b000, 1);
`else
    addv(3'b100, 1, 0, 3'b000, 0);
    addv(3'b000, 1, 0, 3'b000, 0);
`endif
    addv(3'b001, 1, 1, 3'b001, 0);
    addv(3'b010, 1, 1, 3'b010, 1);
`ifdef IMG_RSZ_FWD_OOO_EN
    addv(3'b000, 1, 0, 3'b000, 1);
    addv(3'b000, 1, 0, 3'b000, 0);
`else
    addv(3'b000, 1, 1, 3'b100, 1);
    addv(3'b000, 1, 0, 3'b000, 1);
`endif
    addv(3'b000, 1, 0, 3'b000, 0);
    // Frames 4 and 5: all rows ready at once; counter wraps 3 -> 0 -> 1.
    for (int f = 0; f < 2; f++) begin
      addv(3'b111, 1, 1, 3'b001, 0);
      addv(3'b000, 1, 1, 3'b010, 1);
      addv(3'b000, 1, 1, 3'b100, 1);
      addv(3'b000, 1, 0, 3'b000, 1);
      addv(3'b000, 1, 0, 3'b000, 0);
    end

    #1;
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].comp, vecs[i].rdy, vecs[i].fv, vecs[i].mask, vecs[i].vld);

    // Reset while a row is held; row 1 is complete and ready is high during reset.
    step(3'b001, 0, 1, 3'b001, 0);
    step(3'b000, 0, 0, 3'b000, 1);
    rst = 1'b1;
    step(3'b010, 1, 0, 3'b000, 1);
    rst = 1'b0;
    q.delete();
    cap_cnt = 0;
    exp_frm = '0;
    chk("rst2_vld", 128'(vld), 128'(0));
    chk("rst2_frm", 128'(frm), 128'(0));
    chk("rst2_posy", 128'(posy), 128'(0));
    chk("rst2_last", 128'(last), 128'(0));
    chk("rst2_dat", 128'(dat), 128'(0));
`ifdef IMG_RSZ_FWD_OOO_EN
    step(3'b000, 1, 1, 3'b010, 0);
    step(3'b001, 1, 1, 3'b001, 1);
    step(3'b000, 1, 0, 3'b000, 1);
    step(3'b000, 1, 0, 3'b000, 0);
`else
    step(3'b000, 1, 0, 3'b000, 0);
    step(3'b001, 1, 1, 3'b001, 0);
    step(3'b000, 1, 1, 3'b010, 1);
    step(3'b000, 1, 0, 3'b000, 1);
`endif
    step(3'b000, 1, 0, 3'b000, 0);

    chk("sb_drained", 128'(q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
